// File: rtl/aes_feed_pkg.sv
// Shared types and sizes for the AES block feeder (packer, buffer, dispatch FSM).
package aes_feed_pkg;

  localparam int BLOCK_W         = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } feed_state_e;

endpackage

// File: rtl/aes_block_fifo.sv
// DEPTH x BLOCK_W synchronous FIFO. Head is presented combinationally on rdata.
// A push while full is accepted only when a pop happens in the same cycle.
module aes_block_fifo
  import aes_feed_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata,
  output logic               full,
  output logic               empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               do_push;
  logic               do_pop;

  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; data is not reset, occupancy tracking makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/aes_block_feeder.sv
// Packs 32-bit words (MSW first) into 128-bit blocks, buffers them, and hands
// each block with the shadowed key to aes_cipher_top via a one-cycle ld pulse,
// waiting for the core's done edge before the next dispatch.
// Optional build macro AES_FEED_TIMEOUT_EN: abandon a block after TIMEOUT_CYC
// WAIT cycles without a done edge and raise sticky err_timeout.
module aes_block_feeder
  import aes_feed_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  input  logic [BLOCK_W-1:0]  key_in,
  input  logic                key_we,
  output logic                core_ld,
  output logic [BLOCK_W-1:0]  core_key,
  output logic [BLOCK_W-1:0]  core_text,
  input  logic                core_done,
  output logic                busy,
  output logic [15:0]         blocks_sent,
  output logic                err_timeout
);

  localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_BLOCK - 1);

  feed_state_e                state;
  feed_state_e                state_nxt;
  logic [1:0]                 wcnt;
  logic [BLOCK_W-WORD_W-1:0]  asm_q;
  logic [BLOCK_W-1:0]         assembled;
  logic [BLOCK_W-1:0]         head;
  logic                       hs;
  logic                       push;
  logic                       pop;
  logic                       buf_full;
  logic                       buf_empty;
  logic [BLOCK_W-1:0]         key_sh;
  logic                       key_valid;
  logic                       done_q;
  logic                       done_edge;
  logic                       load;
  logic                       complete;

  // The last word can only be taken if the buffer has room for the finished block.
  assign in_ready  = !rst & ((wcnt != LAST_WORD) | !buf_full);
  assign hs        = in_valid & in_ready;
  assign push      = hs & (wcnt == LAST_WORD);
  assign assembled = {asm_q, in_data};
  assign done_edge = core_done & !done_q;
  assign busy      = (state != IDLE) | !buf_empty;

  // Word counter of the packer.
  always_ff @(posedge clk) begin
    if (rst) wcnt <= '0;
    else if (hs) wcnt <= wcnt + 2'd1;
  end

  // Assembly shift register holds the first three words of the block in flight.
  always_ff @(posedge clk) begin
    if (hs) asm_q <= assembled[BLOCK_W-WORD_W-1:0];
  end

  aes_block_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (assembled),
    .rdata (head),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // Key shadow validity; a write at any time is allowed.
  always_ff @(posedge clk) begin
    if (rst) key_valid <= 1'b0;
    else if (key_we) key_valid <= 1'b1;
  end

  // Key shadow contents; only copied to core_key on dispatch.
  always_ff @(posedge clk) begin
    if (key_we) key_sh <= key_in;
  end

  // Registered done for edge detection, since the core may hold done high.
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else done_q <= core_done;
  end

`ifdef AES_FEED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] wait_cnt;
  logic          tmo;
  logic          err_q;

  assign err_timeout = err_q;

  // WAIT cycle counter (zero on WAIT entry) and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != WAIT) wait_cnt <= '0;
      else wait_cnt <= wait_cnt + TW'(1);
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  // Feature absent: flag stays low; the expression keeps TIMEOUT_CYC referenced.
  assign err_timeout = (TIMEOUT_CYC < 1);
`endif

  // Dispatch FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end

  // Dispatch FSM next state and strobes; a done edge takes priority over timeout.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    complete  = 1'b0;
`ifdef AES_FEED_TIMEOUT_EN
    tmo       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!buf_empty && key_valid) begin
          pop       = 1'b1;
          load      = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = WAIT;
      WAIT: begin
        if (done_edge) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
`ifdef AES_FEED_TIMEOUT_EN
        else if (wait_cnt == TMO_LAST) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Core interface registers; text and key change only on dispatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_ld     <= 1'b0;
      core_key    <= '0;
      core_text   <= '0;
      blocks_sent <= '0;
    end else begin
      core_ld <= load;
      if (load) begin
        core_text <= head;
        core_key  <= key_sh;
      end
      if (complete) blocks_sent <= blocks_sent + 16'd1;
    end
  end

endmodule
